// File: rtl/sdram_if_pkg.sv
// Shared definitions for the SDRAM command interface: command encoding and
// the responder state encoding used by the controller and its BRAM stand-in.
package sdram_if_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE     = 2'd0,
    CMD_WRITE    = 2'd1,
    CMD_READ     = 2'd2,
    CMD_RESERVED = 2'd3
  } sdram_cmd_e;

  typedef logic [2:0] resp_state_t;

  localparam resp_state_t ST_IDLE       = 3'd0;
  localparam resp_state_t ST_WR_CAPTURE = 3'd1;
  localparam resp_state_t ST_WR_GAP     = 3'd2;
  localparam resp_state_t ST_RD_LATENCY = 3'd3;
  localparam resp_state_t ST_RD_BURST   = 3'd4;
  localparam resp_state_t ST_RECOVER    = 3'd5;

endpackage

// File: rtl/sdram_bram_responder_if.sv
// Command/data handshake between the frame-buffer arbiter (master) and the
// SDRAM controller or its BRAM-backed responder (slave).
interface sdram_bram_responder_if #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int DATA_WIDTH    = 16
) ();

  logic [1:0]               command;
  logic [ADDRESS_WIDTH-1:0] data_address;
  logic [DATA_WIDTH-1:0]    data_write;
  logic [DATA_WIDTH-1:0]    data_read;
  logic                     data_read_valid;
  logic                     data_write_done;
  logic                     busy;
  logic                     protocol_error;

  modport master (
    output command,
    output data_address,
    output data_write,
    input  data_read,
    input  data_read_valid,
    input  data_write_done,
    input  busy,
    input  protocol_error
  );

  modport slave (
    input  command,
    input  data_address,
    input  data_write,
    output data_read,
    output data_read_valid,
    output data_write_done,
    output busy,
    output protocol_error
  );

endinterface

// File: rtl/bram_sp_sync.sv
// Single-port RAM with synchronous write and registered read, written so the
// synthesiser maps it onto block RAM.
module bram_sp_sync #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // No reset on the array or read register: contents must survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_bram_responder.sv
// BRAM-backed drop-in for the SDRAM controller: fixed-length wrapping bursts,
// one write word every two cycles, reads delayed by CAS_LATENCY.
module sdram_bram_responder
  import sdram_if_pkg::*;
#(
  parameter int ADDRESS_WIDTH      = 22,
  parameter int DATA_WIDTH         = 16,
  parameter int MEM_DEPTH_LOG2     = 12,
  parameter int READ_BURST_LENGTH  = 8,
  parameter int WRITE_BURST_LENGTH = 8,
  parameter int CAS_LATENCY        = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sdram_bram_responder_if.slave bus
);

  localparam int RAM_AW = (MEM_DEPTH_LOG2 < ADDRESS_WIDTH) ? MEM_DEPTH_LOG2 : ADDRESS_WIDTH;
  localparam int MAX_BL = (READ_BURST_LENGTH > WRITE_BURST_LENGTH) ?
                          READ_BURST_LENGTH : WRITE_BURST_LENGTH;
  localparam int CNT_W  = $clog2(MAX_BL + 1);
  localparam int LAT_W  = $clog2(CAS_LATENCY + 1);

  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_BURST_LENGTH - 1);
  localparam logic [CNT_W-1:0] RD_END  = CNT_W'(READ_BURST_LENGTH);

  // Upper bits of the burst start stay fixed; the low log2(blen) bits count
  // modulo blen, so the burst wraps inside its aligned block.
  function automatic logic [RAM_AW-1:0] beat_addr(
    input logic [RAM_AW-1:0] base,
    input logic [CNT_W-1:0]  beat,
    input int unsigned       blen
  );
    logic [RAM_AW-1:0] mask;
    logic [RAM_AW-1:0] sum;
    mask = RAM_AW'(blen - 1);
    sum  = base + RAM_AW'(beat);
    return (base & ~mask) | (sum & mask);
  endfunction

  resp_state_t       state_q, state_d;
  logic [RAM_AW-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              perr_q, perr_d;

  logic              wr_req;
  logic              rd_req;
  logic              ram_we;
  logic              ram_re;
  logic [RAM_AW-1:0] wr_addr;
  logic [RAM_AW-1:0] rd_addr;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    perr_d  = perr_q;
    wr_req  = 1'b0;
    rd_req  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        base_d = bus.data_address[RAM_AW-1:0];
        cnt_d  = '0;
        case (sdram_cmd_e'(bus.command))
          CMD_WRITE: state_d = ST_WR_CAPTURE;
          CMD_READ: begin
            state_d = ST_RD_LATENCY;
            lat_d   = LAT_W'(CAS_LATENCY);
          end
          CMD_RESERVED: perr_d = 1'b1;
          default: state_d = ST_IDLE;
        endcase
      end

      ST_WR_CAPTURE: begin
        wr_req = 1'b1;
        done_d = 1'b1;
        if (cnt_q == WR_LAST) begin
          state_d = ST_RECOVER;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_WR_GAP;
        end
      end

      ST_WR_GAP: state_d = ST_WR_CAPTURE;

      // The RAM read for each beat is issued one cycle before its valid, so
      // the registered RAM output lines up with data_read_valid.
      ST_RD_LATENCY: begin
        if (lat_q == '0) begin
          rd_req  = 1'b1;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_RD_BURST;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end

      ST_RD_BURST: begin
        if (cnt_q == RD_END) begin
          state_d = ST_RECOVER;
        end else begin
          rd_req  = 1'b1;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end

      ST_RECOVER: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  // Gate RAM strobes with reset so an aborted burst cannot land a write.
  assign ram_we   = wr_req & reset_n;
  assign ram_re   = rd_req & reset_n;
  assign wr_addr  = beat_addr(base_q, cnt_q, WRITE_BURST_LENGTH);
  assign rd_addr  = beat_addr(base_q, cnt_q, READ_BURST_LENGTH);
  assign ram_addr = wr_req ? wr_addr : rd_addr;

  bram_sp_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (bus.data_write),
    .rdata_o (ram_rdata)
  );

  assign bus.data_read       = valid_q ? ram_rdata : '0;
  assign bus.data_read_valid = valid_q;
  assign bus.data_write_done = done_q;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.protocol_error  = perr_q;

endmodule

// File: tb/tb_sdram_bram_responder.sv
// Directed bench for the BRAM-backed SDRAM responder: bursts, wrap, aliasing,
// held commands, mid-burst reset and the reserved command.
module tb_sdram_bram_responder;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;

  sdram_bram_responder_if #(.ADDRESS_WIDTH(22), .DATA_WIDTH(16)) bus ();

  sdram_bram_responder #(
    .ADDRESS_WIDTH      (22),
    .DATA_WIDTH         (16),
    .MEM_DEPTH_LOG2     (12),
    .READ_BURST_LENGTH  (8),
    .WRITE_BURST_LENGTH (8),
    .CAS_LATENCY        (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Issues a write burst and reloads data_write on every done; stops after
  // stop_after done pulses (or a cycle budget).
  task automatic write_burst(input logic [21:0] addr, input logic [15:0] d0, input int stop_after);
    int dones = 0;
    int last  = 0;
    bus.command      = 2'd1;
    bus.data_address = addr;
    bus.data_write   = d0;
    step();
    bus.command = 2'd0;
    for (int cyc = 1; cyc <= 40 && dones < stop_after; cyc++) begin
      step();
      if (bus.data_write_done) begin
        if (dones == 0) chk("wr_first_done", cyc, 1);
        else            chk("wr_done_spacing", cyc - last, 2);
        dones++;
        last = cyc;
        bus.data_write = d0 + 16'(dones);
      end
    end
    chk("wr_done_count", dones, stop_after);
    $display("write addr=0x%06h data0=0x%04h dones=%0d", addr, d0, dones);
  endtask

  // Issues a read burst; word n must equal d0 + ((n+rot) mod 8) for n < nchk.
  task automatic read_burst(input logic [21:0] addr, input logic [15:0] d0, input int rot,
                            input int nchk, input bit hold);
    int nv    = 0;
    int first = 0;
    int lastv = -100;
    bus.command      = 2'd2;
    bus.data_address = addr;
    step();
    if (!hold) bus.command = 2'd0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (bus.data_read_valid) begin
        if (nv == 0) begin
          first = cyc;
          chk("rd_first_latency", cyc, 3);
        end else begin
          chk("rd_consecutive", cyc, first + nv);
        end
        if (nv < nchk) chk("rd_data", bus.data_read, d0 + 16'((nv + rot) % 8));
        nv++;
        lastv = cyc;
      end
      if (nv == 8 && cyc == lastv + 1) begin
        chk("rd_busy_recover", bus.busy, 1'b1);
        if (hold) bus.command = 2'd0;
      end
      if (nv == 8 && cyc == lastv + 2) chk("rd_busy_clear", bus.busy, 1'b0);
    end
    bus.command = 2'd0;
    chk("rd_valid_count", nv, 8);
    $display("read  addr=0x%06h hold=%0d valids=%0d", addr, hold, nv);
  endtask

  initial begin
    int late_dones;
    n_pass           = 0;
    n_total          = 0;
    reset_n          = 1'b0;
    bus.command      = 2'd0;
    bus.data_address = '0;
    bus.data_write   = '0;
    step();
    step();
    chk("rst_valid", bus.data_read_valid, 1'b0);
    chk("rst_done", bus.data_write_done, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_perr", bus.protocol_error, 1'b0);
    chk("rst_data_read", bus.data_read, 16'h0000);
    reset_n = 1'b1;
    step();

    // Plain write then read of the aligned block at 0x10.
    write_burst(22'h000010, 16'hA000, 8);
    step();
    chk("wr_busy_clear", bus.busy, 1'b0);
    chk("wr_done_clear", bus.data_write_done, 1'b0);
    read_burst(22'h000010, 16'hA000, 0, 8, 1'b0);

    // Write starting mid-block wraps within the 8-word block.
    write_burst(22'h000015, 16'hB000, 8);
    step();
    read_burst(22'h000010, 16'hB000, 3, 8, 1'b0);

    // Address bit 12 aliases onto RAM word 0.
    write_burst(22'h001000, 16'hC000, 8);
    step();
    read_burst(22'h000000, 16'hC000, 0, 8, 1'b0);

    // Command held through RECOVER must not start a second burst.
    read_burst(22'h000010, 16'hB000, 3, 8, 1'b1);

    // Reserved command sets the sticky error; it survives a later burst.
    bus.command = 2'd3;
    step();
    bus.command = 2'd0;
    step();
    chk("perr_set", bus.protocol_error, 1'b1);
    chk("perr_busy", bus.busy, 1'b0);
    read_burst(22'h000000, 16'hC000, 0, 8, 1'b0);
    chk("perr_sticky", bus.protocol_error, 1'b1);
    $display("reserved command perr=%0d", bus.protocol_error);

    // Reset after the third done aborts the burst.
    write_burst(22'h000020, 16'hD000, 3);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("abort_valid", bus.data_read_valid, 1'b0);
    chk("abort_done", bus.data_write_done, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_perr", bus.protocol_error, 1'b0);
    chk("abort_data_read", bus.data_read, 16'h0000);
    late_dones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.data_write_done) late_dones++;
    end
    chk("abort_no_dones", late_dones, 0);
    $display("reset mid-burst late_dones=%0d", late_dones);
    read_burst(22'h000020, 16'hD000, 0, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdram_bram_responder.md
Name: sdram_bram_responder

Overview:
- Responder side of the SDRAM controller command interface, i.e. the `command` / `data_address` / `data_write` / `data_read` / `data_read_valid` / `data_write_done` handshake.
- Backs that interface with on-chip block RAM instead of the AS4C4M16SA.
- Drops into the slot of the SDRAM controller so the frame-buffer arbiter can be brought up and simulated without external SDRAM.
- Same burst semantics as the controller: fixed-length bursts, sequential order, wrap inside the burst-aligned block.

Parameters:
- ADDRESS_WIDTH, 22, width of `data_address`.
- DATA_WIDTH, 16, word width.
- MEM_DEPTH_LOG2, 12, RAM holds 2**MEM_DEPTH_LOG2 words; address bits above this are ignored (aliasing).
- READ_BURST_LENGTH, 8, words per read burst; power of 2, at most 2**MEM_DEPTH_LOG2.
- WRITE_BURST_LENGTH, 8, words per write burst; power of 2.
- CAS_LATENCY, 2, extra idle cycles before read data; 1..3.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- command  in  2  0=idle, 1=write burst, 2=read burst, 3=reserved.
- data_address  in  ADDRESS_WIDTH  burst start word address; sampled only in IDLE.
- data_write  in  DATA_WIDTH  write word; sampled on capture edges.
- data_read  out  DATA_WIDTH  read word; meaningful only while data_read_valid=1.
- data_read_valid  out  1  one cycle per read word.
- data_write_done  out  1  one-cycle pulse per write word captured.
- busy  out  1  high whenever the state is not IDLE.
- protocol_error  out  1  sticky; set when command==3 is sampled in IDLE.

Behaviour:
- Reset (edge with reset_n=0):
  - state=IDLE; data_read_valid, data_write_done, busy, protocol_error all 0; data_read=0.
  - RAM contents are not cleared and survive reset.
  - Reset mid-burst aborts the burst; no further done or valid pulses follow.
- States: IDLE, WR_CAPTURE, WR_GAP, RD_LATENCY, RD_BURST, RECOVER.
- IDLE:
  - Samples `command` and `data_address` each edge and latches base=data_address.
  - Sets offset=0 (log2 of burst length bits).
  - command 1 -> WR_CAPTURE; command 2 -> RD_LATENCY with latency counter=CAS_LATENCY.
  - command 0 -> stay in IDLE; command 3 -> stay in IDLE and set protocol_error.
- Word address for beat i: {base[MSBs], (base[low] + i) mod burst length}. The column offset wraps inside the burst-aligned block; upper bits are fixed. The RAM index is the low MEM_DEPTH_LOG2 bits of that address.
- WR_CAPTURE:
  - Writes data_write to RAM[word address(offset)] and asserts data_write_done for exactly this one cycle.
  - If offset==WRITE_BURST_LENGTH-1 -> RECOVER; otherwise offset++ and -> WR_GAP.
- WR_GAP: done=0, no capture for one cycle so the initiator can reload data_write; -> WR_CAPTURE.
- Write throughput is one word per 2 cycles. IDLE samples command=1 at edge a; captures occur at edges a+1, a+3, ..., a+2*WRITE_BURST_LENGTH-1.
- RD_LATENCY: counts down CAS_LATENCY cycles while the RAM read of beat 0 is issued (RAM registered, 1-cycle); -> RD_BURST.
- RD_BURST:
  - data_read_valid=1 on READ_BURST_LENGTH consecutive cycles; data_read = RAM[word address(i)].
  - IDLE samples command=2 at edge a; the first valid is set at edge a+CAS_LATENCY+1.
  - After the last beat -> RECOVER.
- RECOVER:
  - One cycle; valid and done are cleared; `command` is ignored (the initiator is still dropping it); -> IDLE.
  - A command held nonzero is therefore accepted again no earlier than 2 edges after the last done or valid.
- Changes on `command` while busy are ignored; the burst always runs to completion.
- Read-after-write to the same address returns the new data: a write completes before RECOVER, so no hazard exists.
- protocol_error clears only on reset.

Decomposition:
- Package `sdram_if_pkg`:
  - Command enum: CMD_IDLE=0, CMD_WRITE=1, CMD_READ=2, CMD_RESERVED=3.
  - Responder state enum.
  - Shared by the arbiter, the controller and this block.
- One sub-module, `bram_sp_sync`: single-port, synchronous-read RAM (DATA_WIDTH x 2**MEM_DEPTH_LOG2) so block RAM is inferred.
- Burst sequencing, address generation and the FSM stay in the top module.

Test Plan:
- Write then read:
  - Stimulus: command=1, addr=0x000010, data 0xA000..0xA007 reloaded on each done; then command=2, addr=0x000010.
  - Required: exactly 8 done pulses 2 cycles apart; 8 consecutive valids returning 0xA000..0xA007, the first valid 3 cycles after IDLE accepts the read.
- Burst wrap:
  - Stimulus: write 0xB000..0xB007 to addr=0x000015.
  - Required: a read at 0x000010 returns 0xB003,0xB004,0xB005,0xB006,0xB007,0xB000,0xB001,0xB002 (order wraps inside the 8-word block).
- Aliasing:
  - Stimulus: write to addr 0x001000 with MEM_DEPTH_LOG2=12.
  - Required: a read at 0x000000 returns the same 8 words.
- Held command:
  - Stimulus: keep command=2 one cycle past the last valid, then 0.
  - Required: exactly 8 valids, busy low 2 cycles after the last valid, no second burst.
- Reset mid-burst:
  - Stimulus: reset_n=0 for one cycle after the 3rd done of a write.
  - Required: all outputs 0, state IDLE, no further done pulses; the 3 written words are readable afterwards.
- Reserved command:
  - Stimulus: command=3 in IDLE.
  - Required: protocol_error=1 and stays high through later valid bursts until reset.
